// File: rtl/rf_exec_pkg.sv
// Shared definitions for the rf_exec_unit slice: datapath defaults, opcodes and FSM states.
package rf_exec_pkg;

   localparam int RF_WIDTH = 16;
   localparam int RF_AW    = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_SHL = 3'd7;

   typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_EXEC, ST_WB} state_t;

endpackage

// File: rtl/rf_exec_seqmul.sv
// Iterative shift-add multiplier for rf_exec_unit; only built when RF_EXEC_MUL_EN is defined.
`ifdef RF_EXEC_MUL_EN
module rf_exec_seqmul
   import rf_exec_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   // The start edge performs iteration 0, so WIDTH iterations finish WIDTH-1 edges later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         product <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
      end else if (start) begin
         mcand   <= {{WIDTH{1'b0}}, a} << 1;
         mplier  <= b >> 1;
         product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
         cnt     <= CW'(WIDTH - 1);
         busy    <= 1'b1;
      end else if (busy) begin
         if (mplier[0]) product <= product + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt - 1'b1;
         if (cnt == CW'(1)) busy <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/rf_exec_unit.sv
// Execute/write-back stage around the 4x16 register file.
// RF_EXEC_MUL_EN enables the 16-cycle MUL; otherwise opcode 6 completes without a write.
module rf_exec_unit
   import rf_exec_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int AW    = RF_AW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [2:0]       opcode,
   input  logic [AW-1:0]    dst,
   input  logic [AW-1:0]    src,
   output logic [AW-1:0]    Laddr,
   output logic [AW-1:0]    Raddr,
   input  logic [WIDTH-1:0] Lout,
   input  logic [WIDTH-1:0] Rout,
   output logic [WIDTH-1:0] in,
   output logic             RFHwrite,
   output logic             RFLwrite,
   output logic             done,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_c
);

   state_t           state, state_nx;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] opa, opb;
   logic [3:0]       cnt;
   logic             carry;
   logic             wb_write;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;

`ifdef RF_EXEC_MUL_EN
   logic               mul_busy;
   logic [2*WIDTH-1:0] mul_product;

   rf_exec_seqmul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (state == ST_READ && op_r == OP_MUL),
      .a       (Lout),
      .b       (Rout),
      .busy    (mul_busy),
      .product (mul_product)
   );

   assign wb_write = 1'b1;
`else
   assign wb_write = (op_r != OP_MUL);
`endif

   assign op_ready = (state == ST_IDLE);
   assign done     = (state == ST_WB);
   assign RFHwrite = done && wb_write;
   assign RFLwrite = done && wb_write;

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_r)
         OP_ADD:  {alu_c, alu_res} = {1'b0, opa} + {1'b0, opb};
         OP_SUB:  begin
            alu_res = opa - opb;
            alu_c   = (opa < opb);
         end
         OP_AND:  alu_res = opa & opb;
         OP_OR:   alu_res = opa | opb;
         OP_XOR:  alu_res = opa ^ opb;
         OP_MOV:  alu_res = opb;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: if (op_valid) state_nx = ST_READ;
         // wb_write is low only for MUL without the multiplier, which skips EXEC
         ST_READ: state_nx = wb_write ? ST_EXEC : ST_WB;
         ST_EXEC: begin
            case (op_r)
               OP_SHL:  if (cnt <= 4'd1) state_nx = ST_WB;
`ifdef RF_EXEC_MUL_EN
               OP_MUL:  if (!mul_busy) state_nx = ST_WB;
`endif
               default: state_nx = ST_WB;
            endcase
         end
         ST_WB:   state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_r   <= '0;
         Laddr  <= '0;
         Raddr  <= '0;
         opa    <= '0;
         opb    <= '0;
         cnt    <= '0;
         carry  <= 1'b0;
         in     <= '0;
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (op_valid) begin
               op_r  <= opcode;
               Laddr <= dst;
               Raddr <= src;
            end
            ST_READ: begin
               opa <= Lout;
               opb <= Rout;
               cnt <= Rout[3:0];
            end
            ST_EXEC: begin
               case (op_r)
                  // one bit per cycle; the final shift lands straight in the result
                  OP_SHL: begin
                     if (cnt == 4'd0) begin
                        in    <= opa;
                        carry <= 1'b0;
                     end else if (cnt == 4'd1) begin
                        in    <= opa << 1;
                        carry <= opa[WIDTH-1];
                     end else begin
                        opa <= opa << 1;
                        cnt <= cnt - 1'b1;
                     end
                  end
`ifdef RF_EXEC_MUL_EN
                  OP_MUL: if (!mul_busy) begin
                     in    <= mul_product[WIDTH-1:0];
                     carry <= |mul_product[2*WIDTH-1:WIDTH];
                  end
`endif
                  default: begin
                     in    <= alu_res;
                     carry <= alu_c;
                  end
               endcase
            end
            ST_WB: if (wb_write) begin
               flag_z <= (in == '0);
               flag_n <= in[WIDTH-1];
               flag_c <= carry;
            end
            default: ;
         endcase
      end
   end

endmodule
